// File: rtl/pipeexe_mdu_if.sv
// pipeexe_mdu_if: EXE-stage instruction fields in, result/stall out, between pipeline and EXE/MDU.
interface pipeexe_mdu_if #(parameter int WIDTH = 32, parameter int RN_W = 5);
  logic             evalid;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] eimm;
  logic [WIDTH-1:0] epc4;
  logic [RN_W-1:0]  ern0;
  logic [3:0]       ealuc;
  logic             ealuimm;
  logic             eshift;
  logic             ejal;
  logic [3:0]       emdop;
  logic [WIDTH-1:0] ealu;
  logic [RN_W-1:0]  ern;
  logic             estall;
  logic             mdu_busy;
  modport master (output evalid, ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
                  input ealu, ern, estall, mdu_busy);
  modport slave  (input evalid, ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
                  output ealu, ern, estall, mdu_busy);
endinterface

// File: rtl/pipeexe_mdu.sv
// pipeexe_mdu: single-cycle EXE ALU plus iterative shift-add multiply / restoring divide with HI/LO.
module pipeexe_mdu #(
  parameter int WIDTH    = 32,
  parameter int RN_W     = 5,
  parameter int LINK_OFF = 8
) (
  input logic clock,
  input logic reset,
  pipeexe_mdu_if.slave bus
);
  localparam int SHW = ($clog2(WIDTH) < 5) ? $clog2(WIDTH) : 5;
  localparam int CW  = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d;
  logic [WIDTH-1:0]   op_a, op_b, alu, ma, mb, quo, rem;
  logic [WIDTH:0]     msum, rtry, diff;
  logic               mdop, sgn, issue, is_mul;
  assign op_a = bus.eshift ? {{(WIDTH-SHW){1'b0}}, bus.eimm[6 +: SHW]} : bus.ea;
  assign op_b = bus.ealuimm ? bus.eimm : bus.eb;
  always_comb begin
    case (bus.ealuc[2:0])
      3'b000:  alu = op_a + op_b;
      3'b100:  alu = op_a - op_b;
      3'b001:  alu = op_a & op_b;
      3'b101:  alu = op_a | op_b;
      3'b010:  alu = op_a ^ op_b;
      3'b110:  alu = op_b << 16;
      default: alu = !bus.ealuc[2] ? op_b << op_a :
                     bus.ealuc[3] ? WIDTH'($signed(op_b) >>> op_a) : op_b >> op_a;
    endcase
  end
  assign bus.ealu = bus.ejal ? bus.epc4 + WIDTH'(LINK_OFF) :
                    bus.emdop == 4'd5 ? hi_q :
                    bus.emdop == 4'd6 ? lo_q : alu;
  assign bus.ern      = bus.ern0 | {RN_W{bus.ejal}};
  assign mdop         = bus.emdop >= 4'd1 && bus.emdop <= 4'd8;
  assign bus.mdu_busy = state_q != IDLE;
  assign bus.estall   = bus.evalid && bus.mdu_busy && mdop;
  // a busy MDU stalls every mult/div, so an unstalled one is always seen in IDLE
  assign issue  = bus.evalid && !bus.estall && bus.emdop >= 4'd1 && bus.emdop <= 4'd4;
  assign is_mul = bus.emdop <= 4'd2;
  assign sgn    = bus.emdop == 4'd1 || bus.emdop == 4'd3;
  assign ma     = (sgn && bus.ea[WIDTH-1]) ? -bus.ea : bus.ea;
  assign mb     = (sgn && bus.eb[WIDTH-1]) ? -bus.eb : bus.eb;
  assign msum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){p_q[0]}});
  assign rtry   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign diff   = rtry - {1'b0, a_q};
  assign prod   = neg_q ? -p_q : p_q;
  assign quo    = p_q[WIDTH-1:0];
  assign rem    = p_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = is_mul ? MUL : DIV;
          cnt_d   = CW'(WIDTH);
          neg_d   = sgn && (bus.ea[WIDTH-1] ^ bus.eb[WIDTH-1]);
          rneg_d  = sgn && bus.ea[WIDTH-1];
          dz_d    = bus.eb == '0;
          div_d   = !is_mul;
          a_d     = is_mul ? ma : mb;
          p_d     = {{WIDTH{1'b0}}, is_mul ? mb : ma};
        end else if (bus.evalid && bus.emdop == 4'd7) hi_d = bus.ea;
        else if (bus.evalid && bus.emdop == 4'd8) lo_d = bus.ea;
      end
      MUL: begin
        p_d     = {msum, p_q[WIDTH-1:1]};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : MUL;
      end
      DIV: begin
        p_d     = {diff[WIDTH] ? rtry[WIDTH-1:0] : diff[WIDTH-1:0], p_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FIX : DIV;
      end
      default: begin
        // divide by zero leaves quotient all-ones and remainder = |dividend|; only the quotient is pinned
        hi_d    = div_q ? (rneg_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? (dz_q ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
    end
  end
endmodule

// File: tb/tb_pipeexe_mdu.sv
// tb_pipeexe_mdu: random + directed EXE/MDU stimulus against a cycle-level reference model with a scoreboard.
module tb_pipeexe_mdu;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipeexe_mdu_if #(.WIDTH(W), .RN_W(5)) bus ();
  pipeexe_mdu #(.WIDTH(W), .RN_W(5), .LINK_OFF(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct {
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern0;
    logic [3:0]  aluc, mdop;
    logic        aluimm, shift, jal, valid;
  } ins_t;
  typedef struct {
    int          c;
    logic [31:0] alu;
    logic [4:0]  rn;
    logic        stall, busy, chk_alu, valid;
  } exp_t;
  exp_t        sbq[$];
  exp_t        m;
  int          checks = 0, errors = 0;
  logic [31:0] hi_m = 0, lo_m = 0, phi, plo;
  bit          pend = 0;
  int          pend_c = 0, c = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(ins_t i);
    logic [31:0] a, b;
    a = i.shift ? {27'b0, i.eimm[10:6]} : i.ea;
    b = i.aluimm ? i.eimm : i.eb;
    case (i.aluc)
      4'd0, 4'd8:  return a + b;
      4'd4, 4'd12: return a - b;
      4'd1, 4'd9:  return a & b;
      4'd5, 4'd13: return a | b;
      4'd2, 4'd10: return a ^ b;
      4'd6, 4'd14: return b << 16;
      4'd3:        return b << a;
      4'd7:        return b >> a;
      4'd15:       return 32'($signed(b) >>> a);
      default:     return 32'h0;
    endcase
  endfunction
  task automatic mdu_ref(ins_t i);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'($signed(i.ea));
    sb = longint'($signed(i.eb));
    ua = longint'({32'b0, i.ea});
    ub = longint'({32'b0, i.eb});
    r = 64'h0;
    case (i.mdop)
      4'd1: r = 64'(sa * sb);
      4'd2: r = 64'(ua * ub);
      4'd3: r = (i.eb == 0) ? {i.ea, 32'hffffffff} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (i.eb == 0) ? {i.ea, 32'hffffffff} : {32'(ua % ub), 32'(ua / ub)};
    endcase
    phi = r[63:32];
    plo = r[31:0];
  endtask
  task automatic drive(ins_t i);
    bus.evalid  = i.valid;
    bus.ea      = i.ea;
    bus.eb      = i.eb;
    bus.eimm    = i.eimm;
    bus.epc4    = i.epc4;
    bus.ern0    = i.ern0;
    bus.ealuc   = i.aluc;
    bus.ealuimm = i.aluimm;
    bus.eshift  = i.shift;
    bus.ejal    = i.jal;
    bus.emdop   = i.mdop;
  endtask
  // one instruction, repeated each cycle the model says the pipeline is held
  task automatic issue(ins_t i);
    bit   stall;
    exp_t e;
    do begin
      @(posedge clk);
      #1;
      c++;
      if (pend && c >= pend_c) begin
        hi_m = phi;
        lo_m = plo;
        pend = 0;
      end
      drive(i);
      stall     = i.valid && pend && i.mdop >= 1 && i.mdop <= 8;
      e.c       = c;
      e.valid   = i.valid;
      e.alu     = i.jal ? i.epc4 + 32'd8 : i.mdop == 5 ? hi_m : i.mdop == 6 ? lo_m : alu_ref(i);
      e.rn      = i.jal ? 5'd31 : i.ern0;
      e.stall   = stall;
      e.busy    = pend;
      e.chk_alu = i.valid && !stall && (i.jal || i.mdop == 0 || i.mdop == 5 || i.mdop == 6 || i.mdop > 8);
      sbq.push_back(e);
      if (i.valid && !stall) begin
        if (i.mdop >= 1 && i.mdop <= 4) begin
          mdu_ref(i);
          pend   = 1;
          pend_c = c + W + 2;
        end else if (i.mdop == 7) hi_m = i.ea;
        else if (i.mdop == 8) lo_m = i.ea;
      end
    end while (stall);
  endtask
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      m = sbq.pop_front();
      chk($sformatf("estall@%0d", m.c), bus.estall, m.stall);
      chk($sformatf("mdu_busy@%0d", m.c), bus.mdu_busy, m.busy);
      chk($sformatf("ern@%0d", m.c), bus.ern, m.rn);
      if (m.chk_alu) chk($sformatf("ealu@%0d", m.c), bus.ealu, m.alu);
    end
  end
  function automatic ins_t mk(logic [3:0] mdop, logic [31:0] a, logic [31:0] b, logic [3:0] aluc);
    ins_t i;
    i.valid = 1; i.mdop = mdop; i.ea = a; i.eb = b; i.aluc = aluc;
    i.eimm = $urandom; i.epc4 = $urandom; i.ern0 = 5'($urandom);
    i.aluimm = 0; i.shift = 0; i.jal = 0;
    return i;
  endfunction
  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hffffffff;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  ins_t t;
  int   r;
  initial begin
    t = mk(5, 0, 0, 0);
    t.eimm = 0;
    drive(t);
    #3;
    chk("reset mdu_busy", bus.mdu_busy, 0);
    chk("reset estall", bus.estall, 0);
    chk("reset HI via mfhi", bus.ealu, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    issue(mk(0, 5, 7, 4'b0000));
    t = mk(0, 5, 7, 0); t.jal = 1; t.epc4 = 32'h100; t.ern0 = 3;
    issue(t);
    t = mk(0, 0, 32'h80000000, 4'b1111); t.shift = 1; t.eimm = 32'd4 << 6;
    issue(t);
    issue(mk(1, -32'sd3, 32'd7, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(2, 32'hffffffff, 32'hffffffff, 0));
    for (int k = 0; k < 5; k++) issue(mk(0, $urandom, $urandom, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(3, -32'sd7, 32'd2, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(4, 32'd7, 32'd0, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(3, -32'sd9, 32'd0, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(7, 32'h1234, 0, 0));
    issue(mk(8, 32'h5678, 0, 0));
    issue(mk(5, 0, 0, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(1, 32'd3, 32'd3, 0));
    for (int k = 0; k < W; k++) issue(mk(0, 1, 2, 0));
    issue(mk(1, 32'd5, 32'd6, 0));
    issue(mk(6, 0, 0, 0));
    issue(mk(3, 32'd100, 32'd3, 0));
    for (int k = 0; k < 10; k++) issue(mk(0, 1, 1, 0));
    @(posedge clk);
    #1;
    drive(mk(5, 0, 0, 0));
    #1;
    chk("pre-reset estall", bus.estall, 1);
    rst = 1;
    #1;
    chk("async reset mdu_busy", bus.mdu_busy, 0);
    chk("async reset estall", bus.estall, 0);
    @(posedge clk);
    #1;
    rst = 0;
    c++;
    hi_m = 0; lo_m = 0; pend = 0;
    issue(mk(5, 0, 0, 0));
    issue(mk(6, 0, 0, 0));
    for (int k = 0; k < 400; k++) begin
      t = mk(0, rv(), rv(), 0);
      t.valid = $urandom_range(0, 9) != 0;
      do r = $urandom_range(0, 15); while (r == 11);
      t.aluc = 4'(r);
      t.aluimm = 1'($urandom);
      t.shift = 1'($urandom);
      t.jal = $urandom_range(0, 15) == 0;
      t.mdop = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(t);
    end
    @(negedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeexe_mdu.md
Name: pipeexe_mdu

Overview:
- Parametrised next-generation EXE stage for the pipelined MIPS computer.
- Keeps the existing single-cycle ALU path: operand muxing, shift-amount select, JAL link address and rd=31 forcing.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, a multi-cycle state machine and a stall output to the pipeline controller.

Parameters:
- WIDTH, 32, datapath width; power of two, 8 to 64.
- RN_W, 5, destination register number width.
- LINK_OFF, 8, byte offset added to PC for the JAL link address.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- evalid  in  1  EXE holds a real instruction (0 = bubble).
- ea  in  WIDTH  rs operand.
- eb  in  WIDTH  rt operand.
- eimm  in  WIDTH  sign/zero-extended immediate; bits [10:6] carry shamt.
- epc4  in  WIDTH  PC+4 of the instruction.
- ern0  in  RN_W  destination register number before JAL forcing.
- ealuc  in  4  ALU control.
- ealuimm  in  1  B operand = eimm.
- eshift  in  1  A operand = shamt.
- ejal  in  1  JAL instruction.
- emdop  in  4  MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- ealu  out  WIDTH  EXE result.
- ern  out  RN_W  final destination register number.
- estall  out  1  hold IF/ID/EXE registers and insert a bubble into MEM this cycle.
- mdu_busy  out  1  MDU FSM not IDLE.

Behaviour:
- Reset clears state to IDLE, HI=0, LO=0, iteration counter=0; mdu_busy=0 and estall=0 immediately. ealu and ern are combinational and follow inputs.
- Operand A = shamt when eshift=1, else ea. Shamt = eimm[10:6] mod WIDTH, zero-extended.
- Operand B = eimm when ealuimm=1, else eb.
- ALU ops by ealuc (x = don't care):
  - x000 add, x100 sub (both wrapping, no overflow trap).
  - x001 and, x101 or, x010 xor.
  - x110 lui: B << 16.
  - 0011 sll: B << A, 0111 srl: B >> A, 1111 sra: arithmetic B >> A.
- Result select priority: ejal gives epc4+LINK_OFF; else emdop=5 gives HI; else emdop=6 gives LO; else the ALU result.
- ern = ern0 OR all-ones when ejal=1.
- MDU FSM states: IDLE, MUL, DIV, FIX.
  - IDLE to MUL or DIV when evalid=1, estall=0 and emdop is 1-4. The operands are latched as magnitudes for signed ops, plus result-sign flags; counter is loaded with WIDTH.
  - MUL: one shift-add step per cycle. DIV: one restoring-division step per cycle. Counter decrements; at 0 go to FIX.
  - FIX: apply sign correction and write HI/LO at the closing edge; then return to IDLE.
  - Latency: op issued in cycle N; busy from N+1 to N+WIDTH+1; HI/LO valid from N+WIDTH+2.
- Result rules:
  - mult/multu: {HI,LO} = full 2·WIDTH-bit product.
  - div/divu: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - Divide by zero: LO = all-ones, HI = dividend; no trap; same latency.
- estall is asserted when evalid=1, mdu_busy=1 and emdop is 1-8 (mult/div, mfhi/mflo, mthi/mtlo).
- estall is never asserted for emdop=0 or for evalid=0. A mult/div issued without stall does not block the following non-MDU instructions.
- mthi/mtlo write HI or LO from ea at the edge when not stalled; they have no ALU result.
- A new mult/div presented in the FIX cycle stalls one cycle, then is accepted in the next cycle.
- emdop is ignored entirely when evalid=0.
- Reset asserted mid-operation aborts it: IDLE, HI=LO=0, estall and mdu_busy drop asynchronously.

Test Plan:
- Basic ALU and JAL: ea=5, eb=7, ealuc=0000 gives ealu=12. Then ejal=1, epc4=0x100, ern0=3 gives ealu=0x108, ern=31.
- Arithmetic shift: eshift=1, eimm[10:6]=4, eb=0x80000000, ealuc=1111 gives ealu=0xF8000000.
- Signed multiply with stall: mult ea=-3, eb=7 issued at cycle N, then mflo presented at N+1. estall=1 for cycles N+1 to N+33; at N+34 ealu=0xFFFFFFEB and HI=0xFFFFFFFF.
- Unsigned multiply: multu ea=0xFFFFFFFF, eb=0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001. Independent add instructions during the busy period see estall=0.
- Division: div ea=-7, eb=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu ea=7, eb=0 gives LO=0xFFFFFFFF, HI=7.
- Reset mid-divide: assert reset at iteration 10 of a div. mdu_busy and estall go to 0 without waiting for a clock edge; HI=LO=0; a following mfhi returns 0 with no stall.
